// File: rtl/bist_strait_pkg.sv
// Shared encodings and default parameters for the STRAIT BIST sequencer.
package bist_strait_pkg;

   localparam int DEF_NUM_PAT   = 16;
   localparam int DEF_ADDR_W    = 4;
   localparam int DEF_SHIFT_LEN = 8;
   localparam int DEF_CMP_LAT   = 1;
   localparam int DEF_ERR_W     = 8;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SHIFT   = 3'd1;
   localparam logic [2:0] ST_LAUNCH  = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_WRITE   = 3'd4;
   localparam logic [2:0] ST_COMPARE = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;

   typedef logic [1:0] mode_t;

   localparam logic [1:0] MODE_SA   = 2'd0;
   localparam logic [1:0] MODE_TD   = 2'd1;
   localparam logic [1:0] MODE_FULL = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   function automatic logic is_busy(input state_t s);
      return !((s == ST_IDLE) || (s == ST_DONE));
   endfunction

endpackage

// File: rtl/bist_phase_counter.sv
// Loadable down-counter timing the SHIFT and COMPARE phases; zero_o marks the last cycle.
module bist_phase_counter
   import bist_strait_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] cnt_q;

   // Count down to zero and hold there until the next load.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= CNT_ZERO;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != CNT_ZERO) begin
         cnt_q <= cnt_q - CNT_ONE;
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign zero_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/bist_sequencer_strait.sv
// Per-pattern BIST schedule for the STRAIT systolic array: shift, launch/capture,
// RAM write and compare, with saturating error count and first-fail logging.
module bist_sequencer_strait
   import bist_strait_pkg::*;
#(
   parameter int NUM_PAT   = DEF_NUM_PAT,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int SHIFT_LEN = DEF_SHIFT_LEN,
   parameter int CMP_LAT   = DEF_CMP_LAT,
   parameter int ERR_W     = DEF_ERR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        bist_mode,
   input  logic              abort,
   input  logic              compare_fail,
   output logic [ADDR_W-1:0] addr,
   output logic              scan_en,
   output logic              sa_test_en,
   output logic              td_test_en,
   output logic              ram_wr_en,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  error_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic              first_fail_td,
   output logic              first_fail_valid
);

   localparam int PH_MAX = (SHIFT_LEN > CMP_LAT) ? SHIFT_LEN : CMP_LAT;
   localparam int CNT_W  = $clog2(PH_MAX) + 1;

   localparam logic [CNT_W-1:0]  SHIFT_LOAD = CNT_W'(SHIFT_LEN - 1);
   localparam logic [CNT_W-1:0]  CMP_LOAD   = CNT_W'(CMP_LAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_PAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
   localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0]  ERR_ONE    = ERR_W'(1);
   localparam logic [ERR_W-1:0]  ERR_ZERO   = {ERR_W{1'b0}};

   state_t            state_q, state_d;
   mode_t             mode_q, mode_d;
   logic              td_pass_q, td_pass_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] ffa_q, ffa_d;
   logic              fftd_q, fftd_d;
   logic              ffv_q, ffv_d;
   logic              busy_q, done_q, pass_q, scan_q, wr_q, sa_q, td_q;
   logic              ph_load_s;
   logic [CNT_W-1:0]  ph_val_s;
   logic              ph_zero_s;

   bist_phase_counter #(.CNT_W(CNT_W)) u_phase (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ph_load_s),
      .load_val_i (ph_val_s),
      .zero_o     (ph_zero_s)
   );

   // Next-state, address stepping and fail logging.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      td_pass_d = td_pass_q;
      addr_d    = addr_q;
      err_d     = err_q;
      ffa_d     = ffa_q;
      fftd_d    = fftd_q;
      ffv_d     = ffv_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  addr_d    = ADDR_ZERO;
                  err_d     = ERR_ZERO;
                  ffa_d     = ADDR_ZERO;
                  fftd_d    = 1'b0;
                  ffv_d     = 1'b0;
                  mode_d    = bist_mode;
                  td_pass_d = (bist_mode == MODE_TD);
                  state_d   = (bist_mode == MODE_RSVD) ? ST_DONE : ST_SHIFT;
               end else begin
                  state_d = state_q;
               end
            end
            ST_SHIFT: begin
               if (ph_zero_s) begin
                  state_d = td_pass_q ? ST_LAUNCH : ST_CAPTURE;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
            ST_LAUNCH:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_WRITE;
            ST_WRITE:   state_d = ST_COMPARE;
            ST_COMPARE: begin
               if (ph_zero_s) begin
                  if (compare_fail) begin
                     err_d = (err_q != ERR_MAX) ? (err_q + ERR_ONE) : err_q;
                     if (!ffv_q) begin
                        ffa_d  = addr_q;
                        fftd_d = td_pass_q;
                        ffv_d  = 1'b1;
                     end else begin
                        ffv_d = ffv_q;
                     end
                  end else begin
                     err_d = err_q;
                  end
                  if (addr_q != ADDR_LAST) begin
                     addr_d  = addr_q + ADDR_ONE;
                     state_d = ST_SHIFT;
                  end else if ((mode_q == MODE_FULL) && !td_pass_q) begin
                     td_pass_d = 1'b1;
                     addr_d    = ADDR_ZERO;
                     state_d   = ST_SHIFT;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  state_d = ST_COMPARE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Phase counter is loaded on entry to SHIFT or COMPARE.
   always_comb begin
      ph_load_s = ((state_d == ST_SHIFT) && (state_q != ST_SHIFT)) ||
                  ((state_d == ST_COMPARE) && (state_q != ST_COMPARE));
      if (state_d == ST_COMPARE) begin
         ph_val_s = CMP_LOAD;
      end else begin
         ph_val_s = SHIFT_LOAD;
      end
   end

   // State, result registers and outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_SA;
         td_pass_q <= 1'b0;
         addr_q    <= ADDR_ZERO;
         err_q     <= ERR_ZERO;
         ffa_q     <= ADDR_ZERO;
         fftd_q    <= 1'b0;
         ffv_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         scan_q    <= 1'b0;
         wr_q      <= 1'b0;
         sa_q      <= 1'b0;
         td_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         td_pass_q <= td_pass_d;
         addr_q    <= addr_d;
         err_q     <= err_d;
         ffa_q     <= ffa_d;
         fftd_q    <= fftd_d;
         ffv_q     <= ffv_d;
         busy_q    <= is_busy(state_d);
         done_q    <= (state_d == ST_DONE);
         pass_q    <= (state_d == ST_DONE) && (err_d == ERR_ZERO) && (mode_d != MODE_RSVD);
         scan_q    <= (state_d == ST_SHIFT);
         wr_q      <= (state_d == ST_WRITE);
         sa_q      <= is_busy(state_d) && !td_pass_d;
         td_q      <= is_busy(state_d) && td_pass_d;
      end
   end

   assign addr             = addr_q;
   assign scan_en          = scan_q;
   assign sa_test_en       = sa_q;
   assign td_test_en       = td_q;
   assign ram_wr_en        = wr_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign error_count      = err_q;
   assign first_fail_addr  = ffa_q;
   assign first_fail_td    = fftd_q;
   assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_bist_sequencer_strait.sv
// Scoreboard bench for bist_sequencer_strait: expected pass results queued at start, checked at done.
module tb_bist_sequencer_strait;

   localparam int NP = 16;
   localparam int AW = 4;
   localparam int SL = 8;
   localparam int CL = 1;
   localparam int EW = 4;
   localparam int BOUND = 2000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    bist_mode = 2'd0;
   logic          abort = 1'b0;
   logic          compare_fail = 1'b0;
   logic [AW-1:0] addr;
   logic          scan_en, sa_test_en, td_test_en, ram_wr_en, busy, done, pass;
   logic [EW-1:0] error_count;
   logic [AW-1:0] first_fail_addr;
   logic          first_fail_td, first_fail_valid;

   typedef struct {
      int cycles; int err; int ffa; bit fftd; bit ffv; bit pass; int wr; int scan; bit td_seen;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] sa_mask_g = 16'h0000;
   logic [15:0] td_mask_g = 16'h0000;
   bit          noise_g = 1'b0;

   bist_sequencer_strait #(
      .NUM_PAT(NP), .ADDR_W(AW), .SHIFT_LEN(SL), .CMP_LAT(CL), .ERR_W(EW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .bist_mode(bist_mode), .abort(abort),
      .compare_fail(compare_fail), .addr(addr), .scan_en(scan_en),
      .sa_test_en(sa_test_en), .td_test_en(td_test_en), .ram_wr_en(ram_wr_en),
      .busy(busy), .done(done), .pass(pass), .error_count(error_count),
      .first_fail_addr(first_fail_addr), .first_fail_td(first_fail_td),
      .first_fail_valid(first_fail_valid)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input int mode, input logic [15:0] sam, input logic [15:0] tdm, input bit noise);
      exp_t e;
      int   npass;
      bit   td;
      e = '{default: 0};
      npass = (mode == 2) ? 2 : 1;
      for (int p = 0; p < npass; p++) begin
         td = (mode == 1) || (p == 1);
         for (int a = 0; a < NP; a++) begin
            bit f;
            f = noise ? 1'b0 : (td ? tdm[a] : sam[a]);
            if (f) begin
               if (e.err < (1 << EW) - 1) e.err++;
               if (!e.ffv) begin e.ffv = 1; e.ffa = a; e.fftd = td; end
            end
            e.cycles += SL + CL + (td ? 3 : 2);
            e.wr++;
            e.scan += SL;
            if (td) e.td_seen = 1;
         end
      end
      e.pass = (e.err == 0);
      return e;
   endfunction

   task automatic drive_fail();
      if (noise_g) compare_fail = scan_en | ram_wr_en;
      else if (td_test_en) compare_fail = td_mask_g[addr];
      else if (sa_test_en) compare_fail = sa_mask_g[addr];
      else compare_fail = 1'b0;
   endtask

   task automatic run_pass(input int mode, input logic [15:0] sam, input logic [15:0] tdm, input bit noise, input string nm);
      int   cyc, scan, wr;
      bit   tds;
      exp_t e;
      sb_q.push_back(model(mode, sam, tdm, noise));
      sa_mask_g = sam; td_mask_g = tdm; noise_g = noise;
      @(negedge clk);
      start = 1'b1; bist_mode = 2'(mode);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; scan = 0; wr = 0; tds = 0;
      while (!done && cyc < BOUND) begin
         if (scan_en) scan++;
         if (ram_wr_en) wr++;
         if (td_test_en) tds = 1;
         drive_fail();
         @(posedge clk); #1;
         cyc++;
      end
      compare_fail = 1'b0; noise_g = 1'b0;
      e = sb_q.pop_front();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s done: got %0b expected 1", nm, done); end
      n_checks++; if (cyc != e.cycles) begin n_fail++; $display("FAIL %s cycles: got %0d expected %0d", nm, cyc, e.cycles); end
      n_checks++; if (wr != e.wr) begin n_fail++; $display("FAIL %s ram_wr_en pulses: got %0d expected %0d", nm, wr, e.wr); end
      n_checks++; if (scan != e.scan) begin n_fail++; $display("FAIL %s scan_en cycles: got %0d expected %0d", nm, scan, e.scan); end
      n_checks++; if (tds != e.td_seen) begin n_fail++; $display("FAIL %s td_test_en seen: got %0b expected %0b", nm, tds, e.td_seen); end
      n_checks++; if (int'(error_count) != e.err) begin n_fail++; $display("FAIL %s error_count: got %0d expected %0d", nm, error_count, e.err); end
      n_checks++; if (first_fail_valid !== e.ffv) begin n_fail++; $display("FAIL %s first_fail_valid: got %0b expected %0b", nm, first_fail_valid, e.ffv); end
      if (e.ffv) begin
         n_checks++; if (int'(first_fail_addr) != e.ffa) begin n_fail++; $display("FAIL %s first_fail_addr: got %0d expected %0d", nm, first_fail_addr, e.ffa); end
         n_checks++; if (first_fail_td !== e.fftd) begin n_fail++; $display("FAIL %s first_fail_td: got %0b expected %0b", nm, first_fail_td, e.fftd); end
      end
      n_checks++; if (pass !== e.pass) begin n_fail++; $display("FAIL %s pass: got %0b expected %0b", nm, pass, e.pass); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy at done: got %0b expected 0", nm, busy); end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if ({addr, scan_en, sa_test_en, td_test_en, ram_wr_en, busy, done, pass} !== '0) begin
         n_fail++; $display("FAIL reset ctrl outputs: got %0h expected 0", {addr, scan_en, sa_test_en, td_test_en, ram_wr_en, busy, done, pass}); end
      n_checks++; if ({error_count, first_fail_addr, first_fail_td, first_fail_valid} !== '0) begin
         n_fail++; $display("FAIL reset result outputs: got %0h expected 0", {error_count, first_fail_addr, first_fail_td, first_fail_valid}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_mode0_clean();
      run_pass(0, 16'h0000, 16'h0000, 1'b0, "mode0_clean");
   endtask

   task automatic test_mode2_td5();
      run_pass(2, 16'h0000, 16'h0020, 1'b0, "mode2_td5");
   endtask

   task automatic test_mode1_sat();
      run_pass(1, 16'hFFFF, 16'hFFFF, 1'b0, "mode1_sat");
   endtask

   task automatic test_nonsample_fail();
      run_pass(0, 16'hFFFF, 16'hFFFF, 1'b1, "nonsample_fail");
   endtask

   task automatic test_mode3();
      @(negedge clk);
      start = 1'b1; bist_mode = 2'd3;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mode3 done: got %0b expected 1", done); end
      n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL mode3 pass: got %0b expected 0", pass); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mode3 busy: got %0b expected 0", busy); end
      n_checks++; if (error_count !== '0) begin n_fail++; $display("FAIL mode3 error_count: got %0d expected 0", error_count); end
   endtask

   task automatic test_abort();
      int cyc;
      sa_mask_g = 16'h0004; td_mask_g = 16'h0000;
      @(negedge clk);
      start = 1'b1; bist_mode = 2'd0;
      @(posedge clk); #1;
      start = 1'b0; cyc = 0;
      while (!(addr == 4'd7 && scan_en) && cyc < BOUND) begin
         drive_fail();
         @(posedge clk); #1;
         cyc++;
      end
      compare_fail = 1'b0;
      n_checks++; if (cyc >= BOUND) begin n_fail++; $display("FAIL abort reach addr7: got timeout expected addr 7"); end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0 || scan_en !== 1'b0) begin
         n_fail++; $display("FAIL abort idle: got busy=%0b done=%0b scan=%0b expected 0 0 0", busy, done, scan_en); end
      n_checks++; if (error_count !== 4'd1 || first_fail_addr !== 4'd2 || first_fail_valid !== 1'b1) begin
         n_fail++; $display("FAIL abort held results: got err=%0d ffa=%0d ffv=%0b expected 1 2 1", error_count, first_fail_addr, first_fail_valid); end
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_wins busy: got %0b expected 0", busy); end
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++; if (busy !== 1'b1 || addr !== 4'd0 || scan_en !== 1'b1) begin
         n_fail++; $display("FAIL restart: got busy=%0b addr=%0d scan=%0b expected 1 0 1", busy, addr, scan_en); end
      n_checks++; if (error_count !== '0 || first_fail_valid !== 1'b0) begin
         n_fail++; $display("FAIL restart clear: got err=%0d ffv=%0b expected 0 0", error_count, first_fail_valid); end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
   endtask

   task automatic test_reset_mid();
      int cyc;
      sa_mask_g = 16'hFFFF; td_mask_g = 16'hFFFF; noise_g = 1'b0;
      @(negedge clk);
      start = 1'b1; bist_mode = 2'd1;
      @(posedge clk); #1;
      start = 1'b0; cyc = 0;
      while (!(ram_wr_en && addr == 4'd3) && cyc < BOUND) begin
         drive_fail();
         @(posedge clk); #1;
         cyc++;
      end
      drive_fail();
      @(posedge clk); #1;
      n_checks++; if (error_count !== 4'd3 || td_test_en !== 1'b1) begin
         n_fail++; $display("FAIL pre-reset compare: got err=%0d td=%0b expected 3 1", error_count, td_test_en); end
      rst = 1'b0;
      @(posedge clk); #1;
      compare_fail = 1'b0;
      n_checks++; if ({addr, scan_en, sa_test_en, td_test_en, ram_wr_en, busy, done, pass,
                       error_count, first_fail_addr, first_fail_td, first_fail_valid} !== '0) begin
         n_fail++; $display("FAIL reset_mid outputs: got %0h expected 0", {addr, scan_en, sa_test_en, td_test_en, ram_wr_en,
                   busy, done, pass, error_count, first_fail_addr, first_fail_td, first_fail_valid}); end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_mode0_clean();
      test_mode2_td5();
      test_mode1_sat();
      test_nonsample_fail();
      test_mode3();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bist_sequencer_strait.md
# bist_sequencer_strait

Cycle-level sequencer for the STRAIT systolic-array BIST path. It replaces the flag-driven controller with an explicit per-pattern schedule: address stepping, scan shift, optional launch/capture for transition-delay testing, accumulator-RAM write, and a latency-matched compare window. It also provides a saturating error counter and first-fail logging. It sits between the system top's `bist_en`/`bist_mode` inputs and the address generator, ROM, systolic array, accumulator RAM and comparator.

## Interface
- `NUM_PAT`, 16: patterns per pass; addresses run 0..NUM_PAT-1.
- `ADDR_W`, 4: address width; $clog2(NUM_PAT).
- `SHIFT_LEN`, 8: scan-shift cycles per pattern (≥1).
- `CMP_LAT`, 1: cycles from RAM write to a valid `compare_fail` (≥1).
- `ERR_W`, 8: error-counter width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  level; sampled in IDLE and DONE.
- `bist_mode`  in  2  0 = stuck-at, 1 = transition-delay, 2 = stuck-at pass then TD pass, 3 = reserved; latched when `start` is accepted.
- `abort`  in  1  synchronous abort.
- `compare_fail`  in  1  comparator result for the current address.
- `addr`  out  ADDR_W  pattern address to the ROM and RAM.
- `scan_en`  out  1  high during SHIFT.
- `sa_test_en`  out  1  high while busy in a stuck-at pass.
- `td_test_en`  out  1  high while busy in a TD pass.
- `ram_wr_en`  out  1  one pulse per pattern, in WRITE.
- `busy`  out  1  not IDLE and not DONE.
- `done`  out  1  level, high in DONE.
- `pass`  out  1  valid with `done`; 1 iff `error_count`==0 and mode≠3.
- `error_count`  out  ERR_W  failing patterns, saturating.
- `first_fail_addr`  out  ADDR_W  address of the first failure.
- `first_fail_td`  out  1  first failure occurred in a TD pass.
- `first_fail_valid`  out  1  at least one failure logged.

## Operation
- States: IDLE, SHIFT, LAUNCH, CAPTURE, WRITE, COMPARE, DONE.
- IDLE→SHIFT on `start` with mode 0–2. This clears `addr`, `error_count` and the first-fail registers, and latches the mode.
  - Mode 3 goes IDLE→DONE with `pass`=0 and counters cleared.
- SHIFT lasts SHIFT_LEN cycles. It then goes to LAUNCH in a TD pass, otherwise to CAPTURE.
- LAUNCH lasts 1 cycle, TD pass only. CAPTURE lasts 1 cycle. WRITE lasts 1 cycle and asserts `ram_wr_en`.
- COMPARE lasts CMP_LAT cycles. `compare_fail` is sampled only on its last cycle. On a fail:
  - `error_count` increments, saturating at 2^ERR_W-1.
  - If `first_fail_valid`=0, `first_fail_addr` captures `addr`, `first_fail_td` captures the pass type, and `first_fail_valid` is set.
- At the end of COMPARE:
  - If `addr`≠NUM_PAT-1: `addr`+1, go to SHIFT.
  - Else, if mode 2 and in the stuck-at pass: switch to the TD pass, `addr`←0, go to SHIFT.
  - Else go to DONE.
- DONE holds `done`=1 and all results. `start` high in DONE re-arms exactly as from IDLE; `start` low stays in DONE.
- `abort` in any state goes to IDLE next edge. `done`=0; counters and first-fail registers are held for debug.
- `compare_fail` outside the last COMPARE cycle is ignored.
- `addr` is constant from SHIFT through COMPARE of a pattern and never wraps within a pass.

## Timing
- Reset values (any state, including mid-pass): state IDLE; all outputs 0.
- Cycles per pattern: SHIFT_LEN+CMP_LAT+2 for stuck-at; SHIFT_LEN+CMP_LAT+3 for TD.
- The first SHIFT cycle is the cycle after `start` is sampled.
- `done` rises on the edge ending the last COMPARE of the last pass.
- All outputs are registered. Moore decode from state, except the sampled counter updates.
- `abort` and `start` both high in IDLE/DONE: `abort` wins.

## Structure
- Package `bist_strait_pkg` holds:
  - the state enum;
  - mode encodings (MODE_SA=0, MODE_TD=1, MODE_FULL=2, MODE_RSVD=3);
  - default parameter constants.
- One sub-module, `bist_phase_counter`: a loadable down-counter timing the SHIFT and COMPARE phases, with a `zero` flag.
- The FSM, address register and error/first-fail logic stay in the top.

## Test plan
- Mode 0, defaults, `compare_fail`=0:
  - `done` after exactly 176 cycles;
  - 16 `ram_wr_en` pulses;
  - `scan_en` high 8 cycles per pattern;
  - `pass`=1, `td_test_en` never high.
- Mode 2, `compare_fail`=1 only at TD address 5:
  - 368 cycles total; `error_count`=1;
  - `first_fail_addr`=5, `first_fail_td`=1, `pass`=0.
- Mode 1, `compare_fail` stuck at 1, ERR_W=4:
  - `error_count` saturates at 15;
  - `first_fail_addr`=0.
- `compare_fail` pulsed only in non-sampling cycles (SHIFT/WRITE) → `error_count`=0, `pass`=1.
- `abort` at address 7 mid-SHIFT:
  - IDLE next cycle; `busy`=0, `done`=0;
  - a new `start` clears counters, `addr` restarts at 0.
- `rst` low during COMPARE → all outputs 0 next edge. Mode 3 `start` → `done`=1, `pass`=0 one cycle later.
